// File: rtl/ps2_cursor_pkg.sv
// Shared types, screen-region constants and region-test helpers for the PS/2 cursor tracker.
package ps2_cursor_pkg;

  typedef logic signed [8:0] ps2_delta_t;

  localparam int GAME_X_LIMIT = 512;
  localparam int GAME_Y_LIMIT = 480;

  localparam int RETRACT_X0 = 544;
  localparam int RETRACT_X1 = 607;
  localparam int RETRACT_Y0 = 32;
  localparam int RETRACT_Y1 = 63;

  localparam int RETRY_X0 = RETRACT_X0;
  localparam int RETRY_X1 = RETRACT_X1;
  localparam int RETRY_Y0 = 96;
  localparam int RETRY_Y1 = 127;

  function automatic logic in_game_area(input int x, input int y);
    return (x < GAME_X_LIMIT) && (y < GAME_Y_LIMIT);
  endfunction

  function automatic logic in_retract_area(input int x, input int y);
    return (x >= RETRACT_X0) && (x <= RETRACT_X1) && (y >= RETRACT_Y0) && (y <= RETRACT_Y1);
  endfunction

  function automatic logic in_retry_area(input int x, input int y);
    return (x >= RETRY_X0) && (x <= RETRY_X1) && (y >= RETRY_Y0) && (y <= RETRY_Y1);
  endfunction

endpackage

// File: rtl/ps2_axis_accum.sv
// One cursor axis: scale the captured delta, optionally accelerate it, then clamp-accumulate.
// Acceleration is built in only when CURSOR_ACCEL_EN is defined.
module ps2_axis_accum
  import ps2_cursor_pkg::*;
#(
  parameter int POS_W        = 10,
  parameter int MAX          = 639,
  parameter int SHIFT        = 0,
  parameter int ACCEL_THRESH = 16,
  parameter bit INVERT       = 1'b0
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [8:0]       inc_in,
  output logic [POS_W-1:0] pos
);

  localparam int W = POS_W + 2;
  localparam logic [POS_W-1:0]    RST_POS  = POS_W'((MAX + 1) / 2);
  localparam logic [POS_W-1:0]    MAX_POS  = POS_W'(MAX);
  localparam logic signed [W-1:0] MAX_S    = W'(MAX);
  localparam logic signed [W-1:0] THRESH_S = W'(ACCEL_THRESH);
`ifdef CURSOR_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  ps2_delta_t          inc;
  logic signed [W-1:0] ext;
  logic signed [W-1:0] scaled;
  logic signed [W-1:0] delta_d, delta_q;
  logic signed [W-1:0] sum;
  logic                v_b_d, v_b_q;
  logic [POS_W-1:0]    pos_d, pos_q;

  assign inc = inc_in;

  // Stage B: widen before shifting so the negated -256 still fits.
  always_comb begin
    ext    = {{(W - 9){inc[8]}}, inc};
    scaled = ext >>> SHIFT;
    if (INVERT) begin
      scaled = -scaled;
    end
    delta_d = scaled;
    if (ACCEL_ON && ((scaled > THRESH_S) || (scaled < -THRESH_S))) begin
      delta_d = scaled <<< 1;
    end
    v_b_d = valid_in;
  end

  // Stage C: sign bit of the widened sum flags movement past zero.
  always_comb begin
    sum   = $signed({2'b00, pos_q}) + delta_q;
    pos_d = pos_q;
    if (v_b_q) begin
      if (sum[W-1]) begin
        pos_d = '0;
      end else if (sum > MAX_S) begin
        pos_d = MAX_POS;
      end else begin
        pos_d = sum[POS_W-1:0];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      delta_q <= '0;
      v_b_q   <= 1'b0;
      pos_q   <= RST_POS;
    end else begin
      delta_q <= delta_d;
      v_b_q   <= v_b_d;
      pos_q   <= pos_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: rtl/ps2_cursor_tracker.sv
// Cursor tracker: captures PS/2 packets, accumulates per-axis position, derives grid/regions and click pulses.
// Optional acceleration is enabled by defining CURSOR_ACCEL_EN.
module ps2_cursor_tracker
  import ps2_cursor_pkg::*;
#(
  parameter int POS_W        = 10,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int SHIFT        = 0,
  parameter int CELL_LOG2    = 5,
  parameter int ACCEL_THRESH = 16
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic                       data_ready,
  input  logic [8:0]                 x_increment,
  input  logic [8:0]                 y_increment,
  input  logic                       left_button,
  input  logic                       right_button,
  output logic [POS_W-1:0]           pos_x,
  output logic [POS_W-1:0]           pos_y,
  output logic [POS_W-CELL_LOG2-1:0] cell_col,
  output logic [POS_W-CELL_LOG2-1:0] cell_row,
  output logic                       in_game,
  output logic                       left_click,
  output logic                       right_click,
  output logic                       retract,
  output logic                       retry
);

  localparam int CW = POS_W - CELL_LOG2;
  localparam logic [POS_W-1:0] RST_X = POS_W'((X_MAX + 1) / 2);
  localparam logic [POS_W-1:0] RST_Y = POS_W'((Y_MAX + 1) / 2);
  localparam logic [CW-1:0]    RST_COL = RST_X[POS_W-1:CELL_LOG2];
  localparam logic [CW-1:0]    RST_ROW = RST_Y[POS_W-1:CELL_LOG2];
  localparam logic RST_IN_GAME = in_game_area((X_MAX + 1) / 2, (Y_MAX + 1) / 2);
  localparam logic RST_RETRACT = in_retract_area((X_MAX + 1) / 2, (Y_MAX + 1) / 2);
  localparam logic RST_RETRY   = in_retry_area((X_MAX + 1) / 2, (Y_MAX + 1) / 2);

  logic          accept;
  logic          dr_prev_d, dr_prev_q;
  logic [8:0]    x_inc_d, x_inc_q;
  logic [8:0]    y_inc_d, y_inc_q;
  logic          v_a_d, v_a_q;
  logic [CW-1:0] cell_col_d, cell_col_q;
  logic [CW-1:0] cell_row_d, cell_row_q;
  logic          in_game_d, in_game_q;
  logic          retract_hit_d, retract_hit_q;
  logic          retry_hit_d, retry_hit_q;
  logic          left_prev_d, left_prev_q;
  logic          right_prev_d, right_prev_q;
  logic          left_click_d, left_click_q;
  logic          right_click_d, right_click_q;
  logic          retract_d, retract_q;
  logic          retry_d, retry_q;

  // Stage A: a held data_ready produces only one accept.
  always_comb begin
    accept    = data_ready & ~dr_prev_q;
    dr_prev_d = data_ready;
    x_inc_d   = x_inc_q;
    y_inc_d   = y_inc_q;
    if (accept) begin
      x_inc_d = x_increment;
      y_inc_d = y_increment;
    end
    v_a_d = accept;
  end

  ps2_axis_accum #(
    .POS_W       (POS_W),
    .MAX         (X_MAX),
    .SHIFT       (SHIFT),
    .ACCEL_THRESH(ACCEL_THRESH),
    .INVERT      (1'b0)
  ) u_accum_x (
    .sys_clk (sys_clk),
    .reset   (reset),
    .valid_in(v_a_q),
    .inc_in  (x_inc_q),
    .pos     (pos_x)
  );

  ps2_axis_accum #(
    .POS_W       (POS_W),
    .MAX         (Y_MAX),
    .SHIFT       (SHIFT),
    .ACCEL_THRESH(ACCEL_THRESH),
    .INVERT      (1'b1)
  ) u_accum_y (
    .sys_clk (sys_clk),
    .reset   (reset),
    .valid_in(v_a_q),
    .inc_in  (y_inc_q),
    .pos     (pos_y)
  );

  always_comb begin
    cell_col_d    = pos_x[POS_W-1:CELL_LOG2];
    cell_row_d    = pos_y[POS_W-1:CELL_LOG2];
    in_game_d     = in_game_area(int'(pos_x), int'(pos_y));
    retract_hit_d = in_retract_area(int'(pos_x), int'(pos_y));
    retry_hit_d   = in_retry_area(int'(pos_x), int'(pos_y));
  end

  // Region qualifiers use the registered hit, so a press alongside a packet sees the old position.
  always_comb begin
    left_prev_d   = left_button;
    right_prev_d  = right_button;
    left_click_d  = left_button & ~left_prev_q;
    right_click_d = right_button & ~right_prev_q;
    retract_d     = left_click_d & retract_hit_q;
    retry_d       = left_click_d & retry_hit_q;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      dr_prev_q     <= 1'b0;
      x_inc_q       <= '0;
      y_inc_q       <= '0;
      v_a_q         <= 1'b0;
      cell_col_q    <= RST_COL;
      cell_row_q    <= RST_ROW;
      in_game_q     <= RST_IN_GAME;
      retract_hit_q <= RST_RETRACT;
      retry_hit_q   <= RST_RETRY;
      left_prev_q   <= 1'b0;
      right_prev_q  <= 1'b0;
      left_click_q  <= 1'b0;
      right_click_q <= 1'b0;
      retract_q     <= 1'b0;
      retry_q       <= 1'b0;
    end else begin
      dr_prev_q     <= dr_prev_d;
      x_inc_q       <= x_inc_d;
      y_inc_q       <= y_inc_d;
      v_a_q         <= v_a_d;
      cell_col_q    <= cell_col_d;
      cell_row_q    <= cell_row_d;
      in_game_q     <= in_game_d;
      retract_hit_q <= retract_hit_d;
      retry_hit_q   <= retry_hit_d;
      left_prev_q   <= left_prev_d;
      right_prev_q  <= right_prev_d;
      left_click_q  <= left_click_d;
      right_click_q <= right_click_d;
      retract_q     <= retract_d;
      retry_q       <= retry_d;
    end
  end

  assign cell_col    = cell_col_q;
  assign cell_row    = cell_row_q;
  assign in_game     = in_game_q;
  assign left_click  = left_click_q;
  assign right_click = right_click_q;
  assign retract     = retract_q;
  assign retry       = retry_q;

endmodule

// File: tb/tb_ps2_cursor_tracker.sv
// Directed bench for ps2_cursor_tracker: table of packet vectors plus hand-written timing/button sequences.
module tb_ps2_cursor_tracker;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       data_ready = 1'b0;
  logic [8:0] x_increment = '0;
  logic [8:0] y_increment = '0;
  logic       left_button = 1'b0;
  logic       right_button = 1'b0;
  logic [9:0] pos_x, pos_y;
  logic [4:0] cell_col, cell_row;
  logic       in_game, left_click, right_click, retract, retry;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         do_reset;
    logic [8:0] dx;
    logic [8:0] dy;
    int         ex;
    int         ey;
    int         ecol;
    int         erow;
    int         eig;
  } vec_t;

  vec_t vecs[11];

  ps2_cursor_tracker dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .data_ready  (data_ready),
    .x_increment (x_increment),
    .y_increment (y_increment),
    .left_button (left_button),
    .right_button(right_button),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .cell_col    (cell_col),
    .cell_row    (cell_row),
    .in_game     (in_game),
    .left_click  (left_click),
    .right_click (right_click),
    .retract     (retract),
    .retry       (retry)
  );

  always #5 sys_clk = ~sys_clk;

  // Free-running guard so the run always ends even if sequencing goes wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge sys_clk);
    reset = 1'b1;
    data_ready = 1'b0;
    left_button = 1'b0;
    right_button = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
  endtask

  // One packet; returns #1 after the edge where cell_* are valid (accept + 3).
  task automatic applyStimulus(input logic [8:0] dx, input logic [8:0] dy);
    @(negedge sys_clk);
    x_increment = dx;
    y_increment = dy;
    data_ready = 1'b1;
    @(negedge sys_clk);
    data_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  task automatic pressLeft(input string tag, input int exp_retract, input int exp_retry);
    @(negedge sys_clk);
    left_button = 1'b1;
    @(posedge sys_clk);
    #1;
    checkOutput({tag, "_left_click"}, int'(left_click), 1);
    checkOutput({tag, "_retract"}, int'(retract), exp_retract);
    checkOutput({tag, "_retry"}, int'(retry), exp_retry);
    @(posedge sys_clk);
    #1;
    checkOutput({tag, "_left_click_held"}, int'(left_click), 0);
    checkOutput({tag, "_retract_held"}, int'(retract), 0);
    checkOutput({tag, "_retry_held"}, int'(retry), 0);
    @(negedge sys_clk);
    left_button = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 9'h038, 9'h030, 376, 192, 11, 6, 1};
    vecs[1]  = '{1'b1, 9'h100, 9'h000,  64, 240,  2, 7, 1};
    vecs[2]  = '{1'b0, 9'h100, 9'h000,   0, 240,  0, 7, 1};
    vecs[3]  = '{1'b0, 9'h100, 9'h000,   0, 240,  0, 7, 1};
    vecs[4]  = '{1'b1, 9'h0FF, 9'h000, 575, 240, 17, 7, 0};
    vecs[5]  = '{1'b0, 9'h0FF, 9'h000, 639, 240, 19, 7, 0};
    vecs[6]  = '{1'b0, 9'h0FF, 9'h000, 639, 240, 19, 7, 0};
    vecs[7]  = '{1'b0, 9'h000, 9'h100, 639, 479, 19, 14, 0};
    vecs[8]  = '{1'b0, 9'h000, 9'h0FF, 639, 224, 19, 7, 0};
    vecs[9]  = '{1'b0, 9'h000, 9'h0FF, 639,   0, 19, 0, 0};
    vecs[10] = '{1'b0, 9'h100, 9'h1EC, 383,  20, 11, 0, 1};

    doReset();
    @(posedge sys_clk);
    #1;
    checkOutput("rst_pos_x", int'(pos_x), 320);
    checkOutput("rst_pos_y", int'(pos_y), 240);
    checkOutput("rst_cell_col", int'(cell_col), 10);
    checkOutput("rst_cell_row", int'(cell_row), 7);
    checkOutput("rst_in_game", int'(in_game), 1);
    checkOutput("rst_pulses", int'({left_click, right_click, retract, retry}), 0);

`ifndef CURSOR_ACCEL_EN
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_reset) doReset();
      applyStimulus(vecs[i].dx, vecs[i].dy);
      checkOutput($sformatf("vec%0d_pos_x", i), int'(pos_x), vecs[i].ex);
      checkOutput($sformatf("vec%0d_pos_y", i), int'(pos_y), vecs[i].ey);
      checkOutput($sformatf("vec%0d_cell_col", i), int'(cell_col), vecs[i].ecol);
      checkOutput($sformatf("vec%0d_cell_row", i), int'(cell_row), vecs[i].erow);
      checkOutput($sformatf("vec%0d_in_game", i), int'(in_game), vecs[i].eig);
    end

    // Latency: pos at accept+2, cell at accept+3.
    doReset();
    @(negedge sys_clk);
    x_increment = 9'h020;
    y_increment = 9'h000;
    data_ready = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    data_ready = 1'b0;
    @(posedge sys_clk);
    #1;
    checkOutput("lat_pos_x_n1", int'(pos_x), 320);
    @(posedge sys_clk);
    #1;
    checkOutput("lat_pos_x_n2", int'(pos_x), 352);
    checkOutput("lat_cell_col_n2", int'(cell_col), 10);
    @(posedge sys_clk);
    #1;
    checkOutput("lat_cell_col_n3", int'(cell_col), 11);

    // Back-to-back rising edges two cycles apart, +10 each.
    x_increment = 9'h00A;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      data_ready = 1'b1;
      @(negedge sys_clk);
      data_ready = 1'b0;
    end
    @(posedge sys_clk);
    #1;
    checkOutput("b2b_pos_x_two", int'(pos_x), 372);
    @(posedge sys_clk);
    #1;
    checkOutput("b2b_pos_x_three", int'(pos_x), 382);

    // Level held high for ten cycles counts once.
    doReset();
    @(negedge sys_clk);
    x_increment = 9'h008;
    y_increment = 9'h000;
    data_ready = 1'b1;
    repeat (10) @(negedge sys_clk);
    data_ready = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("hold_pos_x", int'(pos_x), 328);

    // Buttons and regions.
    doReset();
    pressLeft("centre", 0, 0);
    applyStimulus(9'h0F0, 9'h0C8);
    checkOutput("btn_pos_x", int'(pos_x), 560);
    checkOutput("btn_pos_y", int'(pos_y), 40);
    checkOutput("btn_in_game", int'(in_game), 0);
    pressLeft("retract_region", 1, 0);
    applyStimulus(9'h000, 9'h1C4);
    checkOutput("btn_pos_y_retry", int'(pos_y), 100);
    pressLeft("retry_region", 0, 1);

    @(negedge sys_clk);
    right_button = 1'b1;
    @(posedge sys_clk);
    #1;
    checkOutput("right_click", int'(right_click), 1);
    checkOutput("right_left_click", int'(left_click), 0);
    checkOutput("right_retry", int'(retry), 0);
    @(posedge sys_clk);
    #1;
    checkOutput("right_click_held", int'(right_click), 0);
    @(negedge sys_clk);
    right_button = 1'b0;

    // Press coincident with accept uses the pre-update region (retry, not retract).
    @(negedge sys_clk);
    x_increment = 9'h000;
    y_increment = 9'h03C;
    data_ready = 1'b1;
    left_button = 1'b1;
    @(posedge sys_clk);
    #1;
    checkOutput("simul_left_click", int'(left_click), 1);
    checkOutput("simul_retry", int'(retry), 1);
    checkOutput("simul_retract", int'(retract), 0);
    @(negedge sys_clk);
    data_ready = 1'b0;
    left_button = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("simul_pos_y", int'(pos_y), 40);
    pressLeft("after_simul", 1, 0);

    // Reset while a packet is in flight.
    applyStimulus(9'h000, 9'h000);
    @(negedge sys_clk);
    x_increment = 9'h038;
    y_increment = 9'h030;
    data_ready = 1'b1;
    @(negedge sys_clk);
    data_ready = 1'b0;
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    checkOutput("midrst_pos_x", int'(pos_x), 320);
    checkOutput("midrst_pos_y", int'(pos_y), 240);
    checkOutput("midrst_cell_col", int'(cell_col), 10);
    checkOutput("midrst_in_game", int'(in_game), 1);

    doReset();
    applyStimulus(9'h014, 9'h000);
    checkOutput("linear_plus20", int'(pos_x), 340);
    applyStimulus(9'h00A, 9'h000);
    checkOutput("linear_plus10", int'(pos_x), 350);
`else
    doReset();
    applyStimulus(9'h014, 9'h000);
    checkOutput("accel_plus20", int'(pos_x), 360);
    applyStimulus(9'h00A, 9'h000);
    checkOutput("accel_plus10", int'(pos_x), 370);
    applyStimulus(9'h000, 9'h014);
    checkOutput("accel_y_plus20", int'(pos_y), 200);
    applyStimulus(9'h1EC, 9'h000);
    checkOutput("accel_minus20", int'(pos_x), 330);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
